// File: rtl/frame_transmitter_if.sv
// Byte-stream producer, frame output and status signals of the frame transmitter.
// The master side is the producer/downstream environment; the slave side is the transmitter.
interface frame_transmitter_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       send;
   logic       tx_ready;
   logic [7:0] frame_data;
   logic       frame_valid;
   logic [7:0] crc_out;
   logic       crc_strobe;
   logic       drop_err;
   logic       busy;

   modport master (
      output in_data, in_valid, send, tx_ready,
      input  in_ready, frame_data, frame_valid, crc_out, crc_strobe, drop_err, busy
   );

   modport slave (
      input  in_data, in_valid, send, tx_ready,
      output in_ready, frame_data, frame_valid, crc_out, crc_strobe, drop_err, busy
   );
endinterface

// File: rtl/frame_transmitter.sv
// Buffers payload bytes in a FIFO, then on send emits payload, END_BYTE and an
// XOR checksum of the payload, honouring downstream stalls via tx_ready.
module frame_transmitter #(
   parameter int unsigned DEPTH    = 16,
   parameter logic [7:0]  END_BYTE = 8'h10
) (
   input logic                 clk,
   input logic                 reset,
   frame_transmitter_if.slave  bus
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_END,
      S_CRC
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    wr_ptr_nxt;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    rd_ptr_nxt;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_nxt;

   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   acc_nxt;
   logic [DATA_W-1:0]   frame_data_q;
   logic [DATA_W-1:0]   frame_data_nxt;
   logic                frame_valid_q;
   logic                frame_valid_nxt;
   logic [DATA_W-1:0]   crc_out_q;
   logic [DATA_W-1:0]   crc_out_nxt;
   logic                crc_strobe_q;
   logic                crc_strobe_nxt;
   logic                drop_err_q;
   logic                drop_err_nxt;
   logic                busy_q;

   logic                in_ready_c;
   logic                wr_fire_c;
   logic                wr_en_c;
   logic                rd_en_c;
   logic [DATA_W-1:0]   head_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Producer handshake; delimiter-valued bytes are accepted but never stored
   assign in_ready_c = (state == S_IDLE) && (count < CNT_W'(DEPTH)) && !reset;
   assign wr_fire_c  = bus.in_valid && in_ready_c;
   assign wr_en_c    = wr_fire_c && (bus.in_data != END_BYTE);
   assign head_c     = mem[rd_ptr];

   // FIFO storage has no reset; emptiness is tracked by pointers and count
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   // FIFO pointer and occupancy update
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count;
      if (wr_en_c) begin
         wr_ptr_nxt = ptr_inc(wr_ptr);
      end
      if (rd_en_c) begin
         rd_ptr_nxt = ptr_inc(rd_ptr);
      end
      case ({wr_en_c, rd_en_c})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // Transmit FSM: next state, datapath and registered-output next values
   always_comb begin
      state_nxt       = state;
      acc_nxt         = acc;
      rd_en_c         = 1'b0;
      frame_data_nxt  = frame_data_q;
      frame_valid_nxt = 1'b0;
      crc_out_nxt     = crc_out_q;
      crc_strobe_nxt  = 1'b0;
      drop_err_nxt    = wr_fire_c && (bus.in_data == END_BYTE);

      case (state)
         S_IDLE: begin
            // A byte written in the same cycle as send joins this frame
            if (bus.send) begin
               state_nxt = (count != '0 || wr_en_c) ? S_PAYLOAD : S_END;
            end
         end
         S_PAYLOAD: begin
            if (bus.tx_ready) begin
               rd_en_c         = 1'b1;
               frame_data_nxt  = head_c;
               frame_valid_nxt = 1'b1;
               acc_nxt         = acc ^ head_c;
               if (count == CNT_W'(1)) begin
                  state_nxt = S_END;
               end
            end
         end
         S_END: begin
            if (bus.tx_ready) begin
               frame_data_nxt  = END_BYTE;
               frame_valid_nxt = 1'b1;
               state_nxt       = S_CRC;
            end
         end
         S_CRC: begin
            if (bus.tx_ready) begin
               crc_out_nxt    = acc;
               crc_strobe_nxt = 1'b1;
               acc_nxt        = '0;
               state_nxt      = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, FIFO control and output registers; reset aborts any frame in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         acc           <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         crc_out_q     <= '0;
         crc_strobe_q  <= 1'b0;
         drop_err_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state         <= state_nxt;
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         count         <= count_nxt;
         acc           <= acc_nxt;
         frame_data_q  <= frame_data_nxt;
         frame_valid_q <= frame_valid_nxt;
         crc_out_q     <= crc_out_nxt;
         crc_strobe_q  <= crc_strobe_nxt;
         drop_err_q    <= drop_err_nxt;
         busy_q        <= (state_nxt != S_IDLE);
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.frame_data  = frame_data_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.crc_out     = crc_out_q;
   assign bus.crc_strobe  = crc_strobe_q;
   assign bus.drop_err    = drop_err_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Scoreboard bench for frame_transmitter: a byte-level model predicts every
// transmitted byte and checksum; a monitor pops and compares DUT output.
module tb_frame_transmitter;

   localparam logic [7:0] END_BYTE = 8'h10;

   logic clk;
   logic reset;

   frame_transmitter_if bus();

   frame_transmitter #(.DEPTH(16), .END_BYTE(END_BYTE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests    = 0;
   int failures = 0;
   int strobes  = 0;
   int bytes_seen = 0;

   logic [7:0] mq[$];      // model FIFO contents
   logic [7:0] exp_q[$];   // expected frame bytes
   logic [7:0] crc_q[$];   // expected checksums
   logic [7:0] last_crc = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: compare every valid byte and checksum pulse against the scoreboard
   always @(posedge clk) begin
      logic txr;
      logic was_busy;
      txr      = bus.tx_ready;
      was_busy = bus.busy;
      #1;
      if (!reset) begin
         if (was_busy && !txr) begin
            check("stall_valid", bus.frame_valid, 0);
         end
         if (bus.frame_valid) begin
            bytes_seen++;
            if (exp_q.size() == 0) check("frame_extra", 1, 0);
            else check("frame_data", bus.frame_data, exp_q.pop_front());
         end
         if (bus.crc_strobe) begin
            strobes++;
            if (crc_q.size() == 0) check("crc_extra", 1, 0);
            else check("crc_out", bus.crc_out, crc_q.pop_front());
         end
      end
   end

   task automatic put_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", bus.in_ready, 1);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      if (b != END_BYTE) mq.push_back(b);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("drop_err", bus.drop_err, (b == END_BYTE));
   endtask

   task automatic commit_frame();
      logic [7:0] acc = 8'h00;
      foreach (mq[i]) begin
         exp_q.push_back(mq[i]);
         acc ^= mq[i];
      end
      exp_q.push_back(END_BYTE);
      crc_q.push_back(acc);
      last_crc = acc;
      mq.delete();
   endtask

   task automatic send_frame(input bit toggle, input bit spam);
      int base = strobes;
      int n = 0;
      @(negedge clk);
      check("crc_hold", bus.crc_out, last_crc);
      bus.send = 1'b1;
      commit_frame();
      @(negedge clk);
      bus.send = 1'b0;
      check("busy_set", bus.busy, 1);
      check("in_ready_busy", bus.in_ready, 0);
      while (strobes == base && n < 300) begin
         bus.tx_ready = toggle ? ((n % 2) == 0) : 1'b1;
         bus.send     = spam && (n < 2);
         @(negedge clk);
         n++;
      end
      bus.tx_ready = 1'b1;
      bus.send     = 1'b0;
      check("frame_done", (strobes != base), 1);
      check("busy_clear", bus.busy, 0);
      check("in_ready_back", bus.in_ready, 1);
      check("sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int n;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.send     = 1'b0;
      bus.tx_ready = 1'b1;
      reset        = 1'b1;
      #1;
      check("rst_frame_data", bus.frame_data, 0);
      check("rst_frame_valid", bus.frame_valid, 0);
      check("rst_crc_out", bus.crc_out, 0);
      check("rst_crc_strobe", bus.crc_strobe, 0);
      check("rst_drop_err", bus.drop_err, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Basic three-byte frame with send pulses during transmission
      put_byte(8'h01); put_byte(8'h02); put_byte(8'h04);
      send_frame(1'b0, 1'b1);
      check("crc_basic", bus.crc_out, 8'h07);

      // Fill to depth; the seventeenth byte must be held off
      for (int i = 0; i < 16; i++) put_byte(8'(8'h20 + i));
      @(negedge clk);
      check("full_ready", bus.in_ready, 0);
      bus.in_data  = 8'h30;
      bus.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("full_hold", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      send_frame(1'b0, 1'b0);
      check("crc_full", bus.crc_out, 8'h00);

      // Delimiter byte in payload is dropped
      put_byte(8'hAA); put_byte(END_BYTE); put_byte(8'h55);
      send_frame(1'b0, 1'b0);
      check("crc_drop", bus.crc_out, 8'hFF);

      // Alternating downstream stall
      put_byte(8'h11); put_byte(8'h22); put_byte(8'h33);
      send_frame(1'b1, 1'b0);
      check("crc_stall", bus.crc_out, 8'h00);

      // Empty frame, with ignored send pulses while busy
      send_frame(1'b0, 1'b1);
      check("crc_empty", bus.crc_out, 8'h00);

      // Reset after the second of five payload bytes
      for (int i = 1; i <= 5; i++) put_byte(8'(i));
      base = bytes_seen;
      @(negedge clk);
      bus.send = 1'b1;
      commit_frame();
      @(negedge clk);
      bus.send = 1'b0;
      n = 0;
      while (bytes_seen < base + 2 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("mid_bytes", (bytes_seen >= base + 2), 1);
      reset = 1'b1;
      exp_q.delete();
      crc_q.delete();
      last_crc = 8'h00;
      base = strobes;
      #1;
      check("mid_frame_valid", bus.frame_valid, 0);
      check("mid_frame_data", bus.frame_data, 0);
      check("mid_crc_out", bus.crc_out, 0);
      check("mid_busy", bus.busy, 0);
      check("mid_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_no_strobe", strobes, base);
      check("mid_idle", bus.busy, 0);

      put_byte(8'h05);
      send_frame(1'b0, 1'b0);
      check("crc_after_reset", bus.crc_out, 8'h05);

      repeat (5) @(negedge clk);
      check("final_bytes_left", exp_q.size(), 0);
      check("final_crc_left", crc_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
